// File: rtl/alu_mdu_control.sv
// ALU control decoder with a multi-cycle multiply/accumulate unit and HI/LO registers.
// Single-cycle ops complete one cycle after acceptance; multiplies after MUL_CYCLES.
module alu_mdu_control #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            alu_op,
    input  logic [5:0]            funct,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    output logic [5:0]            alu_ctrl,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  illegal
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int W2 = 2 * DATA_WIDTH;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [5:0] CTRL_BAD = 6'b111111;
    localparam logic [5:0] F_MFHI   = 6'b010000;
    localparam logic [5:0] F_MFLO   = 6'b010010;

    logic [0:0]            state_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [5:0]            mctrl_q;
    logic                  out_valid_q, illegal_q;
    logic [5:0]            alu_ctrl_q;
    logic [DATA_WIDTH-1:0] result_q, hi_q, lo_q;

    logic                  accept, is_mul, mul_done;
    logic [5:0]            dec_ctrl, op_ctrl;
    logic [DATA_WIDTH-1:0] op_a, op_b;
    logic [W2-1:0]         ext_a, ext_b, product, mul_sum;

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_MUL);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign result    = result_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign illegal   = illegal_q;

    always_comb begin
        dec_ctrl = CTRL_BAD;
        if (alu_op == 5'b00010) begin
            case (funct)
                6'b100000, 6'b100001, 6'b100010, 6'b100011,
                6'b011000, 6'b011001, 6'b011100, 6'b011101,
                6'b100100, 6'b100101, 6'b000000, 6'b000010,
                6'b000011, 6'b100110, 6'b101000, 6'b100111,
                6'b101010, 6'b101011, 6'b010000, 6'b010010,
                6'b001000: dec_ctrl = funct;
                default:   dec_ctrl = CTRL_BAD;
            endcase
        end else begin
            case (alu_op)
                5'd3:    dec_ctrl = 6'b100000;
                5'd4:    dec_ctrl = 6'b100100;
                5'd5:    dec_ctrl = 6'b100101;
                5'd6:    dec_ctrl = 6'b100110;
                5'd7:    dec_ctrl = 6'b101010;
                5'd8:    dec_ctrl = 6'b101011;
                5'd9:    dec_ctrl = 6'b101100;
                5'd10:   dec_ctrl = 6'b101100;
                5'd11:   dec_ctrl = 6'b101101;
                5'd12:   dec_ctrl = 6'b101110;
                5'd13:   dec_ctrl = 6'b101111;
                5'd14:   dec_ctrl = 6'b110000;
                5'd15:   dec_ctrl = 6'b110001;
                5'd16:   dec_ctrl = 6'b110010;
                5'd17:   dec_ctrl = 6'b110011;
                default: dec_ctrl = CTRL_BAD;
            endcase
        end
    end

    assign is_mul = (alu_op == 5'b00010) &&
                    (funct == 6'b011000 || funct == 6'b011001 ||
                     funct == 6'b011100 || funct == 6'b011101);

    // With a one-cycle multiply the live inputs feed the multiplier directly.
    assign op_a    = (MUL_CYCLES == 1) ? src_a : a_q;
    assign op_b    = (MUL_CYCLES == 1) ? src_b : b_q;
    assign op_ctrl = (MUL_CYCLES == 1) ? funct : mctrl_q;

    // funct[0] clear selects signed; funct[2] set selects accumulate.
    assign ext_a   = op_ctrl[0] ? {{DATA_WIDTH{1'b0}}, op_a}
                                : {{DATA_WIDTH{op_a[DATA_WIDTH-1]}}, op_a};
    assign ext_b   = op_ctrl[0] ? {{DATA_WIDTH{1'b0}}, op_b}
                                : {{DATA_WIDTH{op_b[DATA_WIDTH-1]}}, op_b};
    assign product = ext_a * ext_b;
    assign mul_sum = op_ctrl[2] ? ({hi_q, lo_q} + product) : product;

    assign mul_done = ((MUL_CYCLES == 1) && accept && is_mul) ||
                      ((state_q == ST_MUL) && (cnt_q == CW'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mctrl_q     <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            alu_ctrl_q  <= '0;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            out_valid_q <= 1'b0;

            if (mul_done) begin
                {hi_q, lo_q} <= mul_sum;
                result_q     <= mul_sum[DATA_WIDTH-1:0];
                alu_ctrl_q   <= op_ctrl;
                illegal_q    <= 1'b0;
                out_valid_q  <= 1'b1;
            end else if (accept && !is_mul) begin
                alu_ctrl_q  <= dec_ctrl;
                illegal_q   <= (dec_ctrl == CTRL_BAD);
                out_valid_q <= 1'b1;
                if (alu_op == 5'b00010 && funct == F_MFHI) begin
                    result_q <= hi_q;
                end else if (alu_op == 5'b00010 && funct == F_MFLO) begin
                    result_q <= lo_q;
                end else begin
                    result_q <= '0;
                end
            end

            if (accept && is_mul && (MUL_CYCLES > 1)) begin
                state_q <= ST_MUL;
                cnt_q   <= CW'(MUL_CYCLES - 1);
                a_q     <= src_a;
                b_q     <= src_b;
                mctrl_q <= funct;
            end else if (state_q == ST_MUL) begin
                if (cnt_q == CW'(1)) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu_control.sv
// Scoreboard bench for alu_mdu_control: directed cases, then randomized ops against a
// table-driven decode and 64-bit arithmetic reference model.
module tb_alu_mdu_control;

    localparam int MC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_op = '0;
    logic [5:0]  funct = '0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        out_valid, busy, illegal;
    logic [5:0]  alu_ctrl;
    logic [31:0] result, hi, lo;

    alu_mdu_control #(.DATA_WIDTH(32), .MUL_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .alu_ctrl(alu_ctrl), .result(result),
        .hi(hi), .lo(lo), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [5:0]  ctrl;
        logic [31:0] res, h, l;
        logic        ill;
    } exp_t;

    exp_t q[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    int vectors = 0, miscompares = 0;

    logic [5:0] legal_funct [21] = '{6'o40, 6'o41, 6'o42, 6'o43, 6'o30, 6'o31, 6'o34, 6'o35,
                                     6'o44, 6'o45, 6'o00, 6'o02, 6'o03, 6'o46, 6'o50, 6'o47,
                                     6'o52, 6'o53, 6'o20, 6'o22, 6'o10};
    logic [5:0] op_map [15] = '{6'b100000, 6'b100100, 6'b100101, 6'b100110, 6'b101010,
                                6'b101011, 6'b101100, 6'b101100, 6'b101101, 6'b101110,
                                6'b101111, 6'b110000, 6'b110001, 6'b110010, 6'b110011};
    logic [5:0] mul_set [4] = '{6'b011000, 6'b011001, 6'b011100, 6'b011101};

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [5:0] ref_ctrl(logic [4:0] op, logic [5:0] fn);
        if (op == 5'd2) begin
            foreach (legal_funct[i]) if (legal_funct[i] == fn) return fn;
            return 6'h3f;
        end
        if (op >= 5'd3 && op <= 5'd17) return op_map[op - 5'd3];
        return 6'h3f;
    endfunction

    // Reference model: compute the response an operation must produce and queue it.
    function automatic void model(logic [4:0] op, logic [5:0] fn, logic [31:0] a,
                                  logic [31:0] b, int now);
        exp_t        e;
        logic [63:0] prod, acc;
        bit          is_mul = 0;
        foreach (mul_set[i]) if (op == 5'd2 && fn == mul_set[i]) is_mul = 1;
        if (is_mul) begin
            if (fn == 6'b011000 || fn == 6'b011100)
                prod = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
            else
                prod = {32'd0, a} * {32'd0, b};
            acc = (fn == 6'b011100 || fn == 6'b011101) ? {m_hi, m_lo} + prod : prod;
            {m_hi, m_lo} = acc;
            e.due = now + MC; e.ctrl = fn; e.res = m_lo; e.ill = 1'b0;
        end else begin
            e.due  = now + 1;
            e.ctrl = ref_ctrl(op, fn);
            e.ill  = (e.ctrl == 6'h3f);
            e.res  = (op == 5'd2 && fn == 6'b010000) ? m_hi :
                     (op == 5'd2 && fn == 6'b010010) ? m_lo : 32'd0;
        end
        e.h = m_hi;
        e.l = m_lo;
        q.push_back(e);
    endfunction

    // Monitor: pop and compare whenever the DUT signals completion.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious out_valid", {63'd0, out_valid}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency",  64'(cyc), 64'(e.due));
                chk("alu_ctrl", {58'd0, alu_ctrl}, {58'd0, e.ctrl});
                chk("result",   {32'd0, result}, {32'd0, e.res});
                chk("hi",       {32'd0, hi}, {32'd0, e.h});
                chk("lo",       {32'd0, lo}, {32'd0, e.l});
                chk("illegal",  {63'd0, illegal}, {63'd0, e.ill});
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready) begin
            // Junk offered while busy must be dropped.
            in_valid = 1'($urandom);
            alu_op   = 5'($urandom);
            funct    = 6'($urandom);
            src_a    = $urandom;
            src_b    = $urandom;
            @(negedge clk);
            n++;
            if (n > 50) begin
                chk("in_ready timeout", {63'd0, in_ready}, 64'd1);
                return;
            end
        end
        in_valid = 1'b1;
        alu_op   = op;
        funct    = fn;
        src_a    = a;
        src_b    = b;
        model(op, fn, a, b, cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src_a    = $urandom;
        src_b    = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain timeout", 64'(q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        q.delete();
        m_hi = '0;
        m_lo = '0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset state
        do_reset(2);
        chk("reset in_ready",  {63'd0, in_ready}, 64'd1);
        chk("reset busy",      {63'd0, busy}, 64'd0);
        chk("reset hi",        {32'd0, hi}, 64'd0);
        chk("reset lo",        {32'd0, lo}, 64'd0);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);

        // Single-cycle op
        issue(5'b00011, 6'd0, 32'h1234, 32'h5678);
        drain();
        chk("add alu_ctrl", {58'd0, alu_ctrl}, 64'b100000);

        // Signed multiply; junk held on in_valid while busy is ignored
        issue(5'b00010, 6'b011000, 32'hFFFF_FFFE, 32'h0000_0003);
        for (int i = 0; i < MC - 1; i++) begin
            @(negedge clk);
            chk("busy in_ready", {63'd0, in_ready}, 64'd0);
            chk("busy flag",     {63'd0, busy}, 64'd1);
            in_valid = (i < MC - 2);
            alu_op   = 5'd31;
            src_a    = $urandom;
            src_b    = $urandom;
        end
        in_valid = 1'b0;
        drain();
        chk("mult hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("mult lo", {32'd0, lo}, 64'hFFFF_FFFA);
        issue(5'b00010, 6'b010010, 32'd0, 32'd0);
        drain();
        chk("mflo result", {32'd0, result}, 64'hFFFF_FFFA);

        // Unsigned accumulate chain
        issue(5'b00010, 6'b011001, 32'hFFFF_FFFF, 32'd2);
        drain();
        chk("multu hi", {32'd0, hi}, 64'd1);
        chk("multu lo", {32'd0, lo}, 64'hFFFF_FFFE);
        issue(5'b00010, 6'b011101, 32'd1, 32'd1);
        drain();
        chk("maddu1 hi", {32'd0, hi}, 64'd1);
        chk("maddu1 lo", {32'd0, lo}, 64'hFFFF_FFFF);
        issue(5'b00010, 6'b011101, 32'd1, 32'd1);
        drain();
        chk("maddu2 hi", {32'd0, hi}, 64'd2);
        chk("maddu2 lo", {32'd0, lo}, 64'd0);

        // Illegal ops
        issue(5'b00010, 6'b111111, 32'd5, 32'd6);
        drain();
        chk("illegal funct flag", {63'd0, illegal}, 64'd1);
        chk("illegal funct ctrl", {58'd0, alu_ctrl}, 64'h3f);
        chk("illegal funct hi",   {32'd0, hi}, 64'd2);
        issue(5'b11111, 6'd0, 32'd5, 32'd6);
        drain();
        chk("illegal op flag", {63'd0, illegal}, 64'd1);
        chk("illegal op ctrl", {58'd0, alu_ctrl}, 64'h3f);
        chk("illegal op lo",   {32'd0, lo}, 64'd0);

        // Reset mid-multiply aborts it
        issue(5'b00010, 6'b011000, 32'd7, 32'd9);
        in_valid = 1'b1;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        q.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort in_ready",  {63'd0, in_ready}, 64'd1);
        chk("abort out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort hi",        {32'd0, hi}, 64'd0);
        chk("abort lo",        {32'd0, lo}, 64'd0);
        repeat (MC + 2) @(negedge clk);

        // Randomized mix
        for (int n = 0; n < 300; n++) begin
            int r = $urandom_range(0, 99);
            logic [4:0] op;
            logic [5:0] fn;
            if (r < 30) begin
                op = 5'd2; fn = mul_set[$urandom_range(0, 3)];
            end else if (r < 45) begin
                op = 5'd2; fn = $urandom_range(0, 1) ? 6'b010000 : 6'b010010;
            end else if (r < 70) begin
                op = 5'd2; fn = 6'($urandom);
            end else begin
                op = 5'($urandom); fn = 6'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
            end
            issue(op, fn, rand_operand(), rand_operand());
        end
        drain();
        chk("queue empty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_mdu_control.md
ALU_MDU_CONTROL -- requirements
Module: alu_mdu_control

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: operand, result and HI/LO width.
REQ-002 The block SHALL have parameter MUL_CYCLES, default 4: multiply latency in cycles; legal values are 1 and above.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operation offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept; a transfer occurs when in_valid and in_ready are both high.
REQ-007 The block SHALL have port alu_op, input, 5 bits: main-decoder operation class.
REQ-008 The block SHALL have port funct, input, 6 bits: R-type function field.
REQ-009 The block SHALL have ports src_a and src_b, input, DATA_WIDTH bits each: operands.
REQ-010 The block SHALL have port out_valid, output, 1 bit: one-cycle completion pulse; there is no backpressure.
REQ-011 The block SHALL have port alu_ctrl, output, 6 bits: registered decoded ALU code.
REQ-012 The block SHALL have port result, output, DATA_WIDTH bits: MDU result.
REQ-013 The block SHALL have ports hi and lo, output, DATA_WIDTH bits each: architectural HI/LO registers.
REQ-014 The block SHALL have port busy, output, 1 bit: multiply in progress.
REQ-015 The block SHALL have port illegal, output, 1 bit: undecodable operation, qualified by out_valid.

Function
REQ-016 Decode for alu_op=00010 SHALL set alu_ctrl equal to funct when funct is one of: 100000, 100001, 100010, 100011, 011000, 011001, 011100, 011101, 100100, 100101, 000000, 000010, 000011, 100110, 101000, 100111, 101010, 101011, 010000, 010010, 001000; any other funct SHALL give 111111.
REQ-017 Decode for alu_op 00011..10001 SHALL map, in order, to: 100000, 100100, 100101, 100110, 101010, 101011, 101100, 101100, 101101, 101110, 101111, 110000, 110001, 110010, 110011; any other alu_op SHALL give 111111.
REQ-018 The block SHALL have two states: IDLE and MUL; in_ready SHALL equal (state==IDLE) and busy SHALL equal (state==MUL).
REQ-019 A single-cycle op accepted in cycle T SHALL drive out_valid=1 with registered alu_ctrl in cycle T+1.
REQ-020 The multiply ops SHALL be funct 011000 (MULT, signed), 011001 (MULTU), 011100 (MADD, signed) and 011101 (MADDU), all under alu_op=00010.
REQ-021 A multiply accepted in cycle T SHALL drive out_valid in cycle T+MUL_CYCLES, with in_ready low in cycles T+1 through T+MUL_CYCLES-1.
REQ-022 For a multiply, IDLE SHALL go to MUL on acceptance when MUL_CYCLES>1; a down-counter loaded with MUL_CYCLES-1 SHALL return MUL to IDLE when it reaches 1.
REQ-023 When MUL_CYCLES=1, multiply timing SHALL be identical to single-cycle ops and the MUL state SHALL never be entered.
REQ-024 Operands SHALL be captured at acceptance; later changes to src_a/src_b SHALL NOT affect the product.
REQ-025 The product SHALL be 2*DATA_WIDTH bits, signed or unsigned per op.
REQ-026 MULT/MULTU SHALL load {hi,lo} with the product.
REQ-027 MADD/MADDU SHALL load {hi,lo} with {hi,lo}+product, modulo 2^(2*DATA_WIDTH).
REQ-028 The new hi/lo SHALL be visible in the same cycle as out_valid, with result=new lo.
REQ-029 MFHI (010000) SHALL set result=hi and MFLO (010010) SHALL set result=lo, as single-cycle ops; an MFHI/MFLO accepted in the out_valid cycle of a multiply SHALL return the updated value.
REQ-030 All other ops SHALL set result=0; hi/lo SHALL change only on multiply completion or reset.
REQ-031 An undecodable op SHALL complete as single-cycle with illegal=1, alu_ctrl=111111, result=0 and hi/lo unchanged.
REQ-032 in_valid while in_ready=0 SHALL be ignored and SHALL NOT be queued.

Reset
REQ-033 On a clock edge with rst=1, the block SHALL enter IDLE, clear the counter and set hi=lo=result=0, alu_ctrl=0, out_valid=0 and illegal=0.
REQ-034 Reset SHALL take priority over acceptance and completion.
REQ-035 Reset asserted mid-multiply SHALL abort the operation: no out_valid and no HI/LO update.
REQ-036 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-037 Reset check: hold rst 2 cycles then release -> in_ready=1, busy=0, hi=lo=0, out_valid=0.
REQ-038 Single-cycle op (DATA_WIDTH=32, MUL_CYCLES=4): alu_op=00011 accepted at T -> out_valid at T+1, alu_ctrl=100000, result=0, illegal=0.
REQ-039 Signed multiply (DATA_WIDTH=32, MUL_CYCLES=4): MULT a=FFFFFFFE, b=00000003 at T -> in_ready low T+1..T+3; at T+4 out_valid=1, hi=FFFFFFFF, lo=FFFFFFFA; then MFLO -> result=FFFFFFFA.
REQ-040 Unsigned accumulate (DATA_WIDTH=32, MUL_CYCLES=4): MULTU FFFFFFFF*2 -> hi=1, lo=FFFFFFFE; then MADDU 1*1 -> hi=1, lo=FFFFFFFF; then MADDU 1*1 again -> hi=2, lo=0.
REQ-041 Illegal op: alu_op=00010, funct=111111 -> out_valid with illegal=1, alu_ctrl=111111, hi/lo unchanged; alu_op=11111 -> same response.
REQ-042 Reset mid-multiply: rst at T+2 of a MULT -> no out_valid, hi=lo=0, in_ready=1 at T+3; in_valid held during busy produces no extra completion.
